// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg -- shared types and constants for the program-counter stack
// and the instruction decoder.
//   PC_W        : program counter width (12 bits, 4 KiB ROM space)
//   NIBBLE_W    : address bus nibble width
//   STACK_DEPTH : number of return-address slots
//   pc_t        : program counter / return address type
// Helpers ptr_inc/ptr_dec step the circular stack pointer modulo STACK_DEPTH.
package pc_stack_pkg;

    localparam int PC_W        = 12;
    localparam int NIBBLE_W    = 4;
    localparam int STACK_DEPTH = 3;

    typedef logic [PC_W-1:0]     pc_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [1:0]          ptr_t;

    localparam ptr_t PTR_LAST  = ptr_t'(STACK_DEPTH - 1);
    localparam ptr_t DEPTH_MAX = ptr_t'(STACK_DEPTH);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic ptr_t ptr_dec(input ptr_t p);
        return (p == 2'd0) ? PTR_LAST : p - 2'd1;
    endfunction

endpackage

// File: rtl/pc_stack_lifo.sv
// pc_stack_lifo -- 3-entry circular return-address LIFO.
// Ports:
//   clk, rstN : clock, async active-low reset
//   push      : write wdata at the pointer, advance pointer, depth +1 (sat 3)
//   pop       : retreat pointer, depth -1 (sat 0); rdata is valid before the edge
//   wdata     : return address to save
//   rdata     : entry at pointer-1, i.e. the top of stack
//   depth     : number of valid entries 0..3
//   err       : sticky overflow/underflow flag, built only when PC_STACK_ERR_EN
//               is defined, otherwise tied to 0
// Overflow silently overwrites the oldest entry and underflow still reads the
// slot below the pointer; the pointer moves regardless of depth so the
// storage behaves as a pure ring.
module pc_stack_lifo
    import pc_stack_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       push,
    input  logic       pop,
    input  pc_t        wdata,
    output pc_t        rdata,
    output logic [1:0] depth,
    output logic       err
);

    pc_t  entries_q [STACK_DEPTH];
    pc_t  entries_d [STACK_DEPTH];
    ptr_t ptr_q, ptr_d;
    ptr_t depth_q, depth_d;

    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        depth_d   = depth_q;
        if (push) begin
            entries_d[ptr_q] = wdata;
            ptr_d            = ptr_inc(ptr_q);
            if (depth_q != DEPTH_MAX) depth_d = depth_q + 2'd1;
        end else if (pop) begin
            ptr_d = ptr_dec(ptr_q);
            if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < STACK_DEPTH; i++) entries_q[i] <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
        end else begin
            entries_q <= entries_d;
            ptr_q     <= ptr_d;
            depth_q   <= depth_d;
        end
    end

    assign rdata = entries_q[ptr_dec(ptr_q)];
    assign depth = depth_q;

`ifdef PC_STACK_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (push && (depth_q == DEPTH_MAX))
              | (pop && !push && (depth_q == 2'd0));
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/pc_stack.sv
// pc_stack -- program counter with 3-level return stack and address nibble mux.
// Ports:
//   clk, rstN            : clock, async active-low reset
//   a1, a2, a3           : one-hot address-phase strobes
//   pcIncPulse           : increment pc at the end of this cycle
//   commitPulse          : X3 commit; qualifies every control-flow input
//   jumpEn, pageJumpEn   : full 12-bit jump / in-page (low byte) jump
//   pushEn, popEn        : save return address with jump / return
//   jumpAddr             : jump target
//   pc                   : registered program counter
//   addrNibble, addrValid: address bus nibble and its phase-valid flag
//   depth, stackErr      : stack occupancy and sticky error flag
// Build option: define PC_STACK_ERR_EN to build overflow/underflow detection.
module pc_stack
    import pc_stack_pkg::*;
(
    input  logic                clk,
    input  logic                rstN,
    input  logic                a1,
    input  logic                a2,
    input  logic                a3,
    input  logic                pcIncPulse,
    input  logic                commitPulse,
    input  logic                jumpEn,
    input  logic                pageJumpEn,
    input  logic                pushEn,
    input  logic                popEn,
    input  logic [PC_W-1:0]     jumpAddr,
    output logic [PC_W-1:0]     pc,
    output logic [NIBBLE_W-1:0] addrNibble,
    output logic                addrValid,
    output logic [1:0]          depth,
    output logic                stackErr
);

    pc_t  pc_q, pc_d;
    pc_t  stack_rdata;
    logic do_pop, do_push;

    // Pop outranks jump, so a push is only honoured when no pop is committed.
    assign do_pop  = commitPulse & popEn;
    assign do_push = commitPulse & ~popEn & jumpEn & pushEn;

    // Commit wins over a coincident increment. The pushed return address and
    // the page-jump high bits both come from pc_q, which already holds the
    // post-fetch value by X3.
    always_comb begin
        pc_d = pc_q;
        if (commitPulse) begin
            if (popEn)           pc_d = stack_rdata;
            else if (jumpEn)     pc_d = jumpAddr;
            else if (pageJumpEn) pc_d = {pc_q[PC_W-1:8], jumpAddr[7:0]};
        end else if (pcIncPulse) begin
            pc_d = pc_q + pc_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    always_comb begin
        addrNibble = '0;
        if (a1)      addrNibble = pc_q[3:0];
        else if (a2) addrNibble = pc_q[7:4];
        else if (a3) addrNibble = pc_q[11:8];
    end

    assign addrValid = a1 | a2 | a3;
    assign pc        = pc_q;

    pc_stack_lifo u_lifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (pc_q),
        .rdata (stack_rdata),
        .depth (depth),
        .err   (stackErr)
    );

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        rstN;
    logic        a1, a2, a3;
    logic        pcIncPulse, commitPulse, jumpEn, pageJumpEn, pushEn, popEn;
    logic [11:0] jumpAddr;
    logic [11:0] pc;
    logic [3:0]  addrNibble;
    logic        addrValid;
    logic [1:0]  depth;
    logic        stackErr;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: PC as an integer, stack as a ring of 3 return addresses
    int m_pc;
    int m_stack [3];
    int m_ptr;
    int m_depth;
    int m_err;

    pc_stack dut (
        .clk         (clk),
        .rstN        (rstN),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .pcIncPulse  (pcIncPulse),
        .commitPulse (commitPulse),
        .jumpEn      (jumpEn),
        .pageJumpEn  (pageJumpEn),
        .pushEn      (pushEn),
        .popEn       (popEn),
        .jumpAddr    (jumpAddr),
        .pc          (pc),
        .addrNibble  (addrNibble),
        .addrValid   (addrValid),
        .depth       (depth),
        .stackErr    (stackErr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ptr = 0; m_depth = 0; m_err = 0;
        for (int i = 0; i < 3; i++) m_stack[i] = 0;
    endtask

    task automatic model_edge(input bit inc, commit, jmp, pjmp, push, pop, input int addr);
        if (commit && pop) begin
            m_ptr = (m_ptr + 2) % 3;
            m_pc  = m_stack[m_ptr];
            if (m_depth == 0) m_err = 1; else m_depth--;
        end else if (commit && jmp) begin
            if (push) begin
                m_stack[m_ptr] = m_pc;
                m_ptr = (m_ptr + 1) % 3;
                if (m_depth == 3) m_err = 1; else m_depth++;
            end
            m_pc = addr;
        end else if (commit && pjmp) begin
            m_pc = (m_pc / 256) * 256 + (addr % 256);
        end else if (!commit && inc) begin
            m_pc = (m_pc + 1) % 4096;
        end
    endtask

    function automatic int exp_err();
`ifdef PC_STACK_ERR_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    // strb: 0 none, 1 A1, 2 A2, 3 A3
    task automatic step(input int strb, input bit inc, commit, jmp, pjmp, push, pop,
                        input int addr);
        @(negedge clk);
        a1 = (strb == 1); a2 = (strb == 2); a3 = (strb == 3);
        pcIncPulse = inc; commitPulse = commit; jumpEn = jmp; pageJumpEn = pjmp;
        pushEn = push; popEn = pop; jumpAddr = 12'(addr);
        #1;
        check_val("nibble", int'(addrNibble), (strb == 0) ? 0 : (m_pc >> (4 * (strb - 1))) % 16);
        check_val("valid", int'(addrValid), (strb != 0) ? 1 : 0);
        @(posedge clk);
        model_edge(inc, commit, jmp, pjmp, push, pop, addr);
        #1;
        check_val("pc", int'(pc), m_pc);
        check_val("depth", int'(depth), m_depth);
        check_val("err", int'(stackErr), exp_err());
    endtask

    task automatic instr(input bit inc, commit, jmp, pjmp, push, pop, input int addr);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        step(3, inc, 0, 0, 0, 0, 0, 0);
        step(0, 0, commit, jmp, pjmp, push, pop, addr);
    endtask

    task automatic jump_to(input int addr);
        step(0, 0, 1, 1, 0, 0, 0, addr);
    endtask

    initial begin
        rstN = 1'b0;
        a1 = 0; a2 = 0; a3 = 0;
        pcIncPulse = 0; commitPulse = 0; jumpEn = 0; pageJumpEn = 0;
        pushEn = 0; popEn = 0; jumpAddr = '0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_pc", int'(pc), 0);
        check_val("rst_depth", int'(depth), 0);
        check_val("rst_err", int'(stackErr), 0);
        check_val("rst_nibble", int'(addrNibble), 0);
        rstN = 1'b1;

        // three fetch microcycles; third one shows pc=2 on the bus
        instr(1, 0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_val("mc3_a1", int'(addrNibble), 2);
        step(2, 0, 0, 0, 0, 0, 0, 0);
        check_val("mc3_a2", int'(addrNibble), 0);
        step(3, 1, 0, 0, 0, 0, 0, 0);
        check_val("mc3_a3", int'(addrNibble), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_val("mc3_pc", int'(pc), 3);

        // carries and wrap
        jump_to('h0FF);
        step(3, 1, 0, 0, 0, 0, 0, 0);
        check_val("inc_0ff", int'(pc), 'h100);
        jump_to('hFFF);
        step(3, 1, 0, 0, 0, 0, 0, 0);
        check_val("inc_fff", int'(pc), 'h000);

        // end-of-page in-page jump uses post-increment page
        jump_to('h1FF);
        instr(1, 1, 0, 1, 0, 0, 'h034);
        check_val("page_jump", int'(pc), 'h234);

        // JMS / BBL
        jump_to('h101);
        instr(1, 1, 1, 0, 1, 0, 'h500);
        check_val("jms_pc", int'(pc), 'h500);
        check_val("jms_depth", int'(depth), 1);
        instr(1, 1, 0, 0, 0, 1, 0);
        check_val("bbl_pc", int'(pc), 'h102);
        check_val("bbl_depth", int'(depth), 0);

        // four nested calls overflow, four returns underflow
        jump_to('h00F);
        instr(1, 1, 1, 0, 1, 0, 'h01F);
        instr(1, 1, 1, 0, 1, 0, 'h02F);
        instr(1, 1, 1, 0, 1, 0, 'h03F);
        instr(1, 1, 1, 0, 1, 0, 'h100);
        check_val("nest_depth", int'(depth), 3);
        instr(1, 1, 0, 0, 0, 1, 0);
        check_val("ret1", int'(pc), 'h040);
        instr(1, 1, 0, 0, 0, 1, 0);
        check_val("ret2", int'(pc), 'h030);
        instr(1, 1, 0, 0, 0, 1, 0);
        check_val("ret3", int'(pc), 'h020);
        instr(1, 1, 0, 0, 0, 1, 0);
        check_val("ret4", int'(pc), 'h040);
        check_val("ret_depth", int'(depth), 0);
`ifdef PC_STACK_ERR_EN
        check_val("nest_err", int'(stackErr), 1);
`else
        check_val("nest_err", int'(stackErr), 0);
`endif

        // pop beats jump; commit beats increment; controls without commit ignored
        jump_to('h321);
        step(0, 0, 1, 1, 0, 1, 0, 'h777);
        step(0, 0, 1, 1, 1, 1, 1, 'h9AB);
        check_val("pop_wins", int'(pc), m_pc);
        step(3, 1, 1, 1, 0, 0, 0, 'h456);
        check_val("commit_wins", int'(pc), 'h456);
        step(0, 0, 0, 1, 1, 1, 1, 'hABC);
        check_val("no_commit", int'(pc), 'h456);
        step(0, 0, 1, 0, 0, 1, 0, 'h111);
        check_val("push_no_jump", int'(depth), m_depth);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 4095)));
        end

        // async reset in the middle of A2
        jump_to('h5A5);
        step(1, 0, 1, 1, 0, 1, 0, 'h6B6);
        @(negedge clk);
        a2 = 1'b1; pcIncPulse = 0; commitPulse = 0;
        #2;
        rstN = 1'b0;
        #1;
        check_val("arst_pc", int'(pc), 0);
        check_val("arst_nibble", int'(addrNibble), 0);
        check_val("arst_depth", int'(depth), 0);
        check_val("arst_err", int'(stackErr), 0);
        a2 = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("arst_idle_nib", int'(addrNibble), 0);
        rstN = 1'b1;
        // stack contents cleared: an underflow pop returns 0
        step(0, 0, 1, 0, 0, 0, 1, 0);
        check_val("arst_stack", int'(pc), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
